// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared FSM state encoding and default target address
package i2c_target_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } i2c_state_e;
    localparam logic [6:0] DEFAULT_TGT_ADDR = 7'h50;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop SCL/SDA synchronizer with SCL edge and START/STOP detection
module i2c_bus_sync (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic SCL,
    input  logic SDA,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [1:0] scl_ff, sda_ff;
    logic scl_q, sda_q, scl_s;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], SCL};
            sda_ff <= {sda_ff[0], SDA};
            scl_q  <= scl_ff[1];
            sda_q  <= sda_ff[1];
        end
    end
    assign scl_s    = scl_ff[1];
    assign sda_s    = sda_ff[1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    // SCL must be high on both samples so an SCL edge never looks like START/STOP
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing NREG byte registers behind an auto-incrementing pointer
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = DEFAULT_TGT_ADDR,
    parameter int         NREG     = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    SCL,
    input  logic                    SDA,
    output logic                    SDA_ENABLE,
    output logic                    BUSY,
    output logic                    WR_VALID,
    output logic [$clog2(NREG)-1:0] WR_PTR,
    output logic [7:0]              WR_DATA
);
    localparam int PW = $clog2(NREG);
    i2c_state_e st, st_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sr, sr_n, rx_byte, rd_byte, wr_data_n;
    logic [PW-1:0] ptr, ptr_n, wr_ptr_n;
    logic rw, rw_n, sda_en_n, busy_n, wr_valid_n;
    logic sda_s, scl_rise, scl_fall, start, stop;
    logic [7:0] regs [NREG];

    i2c_bus_sync u_sync (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .SCL      (SCL),
        .SDA      (SDA),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign rx_byte = {sr[6:0], sda_s};
    assign rd_byte = regs[ptr];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            st         <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            SDA_ENABLE <= 1'b0;
            BUSY       <= 1'b0;
            WR_VALID   <= 1'b0;
            WR_PTR     <= '0;
            WR_DATA    <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            SDA_ENABLE <= sda_en_n;
            BUSY       <= busy_n;
            WR_VALID   <= wr_valid_n;
            WR_PTR     <= wr_ptr_n;
            WR_DATA    <= wr_data_n;
            if (wr_valid_n) regs[ptr] <= rx_byte;
        end
    end

    // cnt counts bits shifted in receive states and bits driven in RDATA (0 = next byte not loaded yet)
    always_comb begin
        st_n       = st;
        cnt_n      = cnt;
        sr_n       = sr;
        ptr_n      = ptr;
        rw_n       = rw;
        sda_en_n   = SDA_ENABLE;
        busy_n     = BUSY;
        wr_valid_n = 1'b0;
        wr_ptr_n   = WR_PTR;
        wr_data_n  = WR_DATA;
        if (stop) begin
            st_n     = IDLE;
            cnt_n    = '0;
            sda_en_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start) begin
            st_n     = ADDR;
            cnt_n    = '0;
            sda_en_n = 1'b0;
        end else begin
            case (st)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        sr_n  = rx_byte;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (st == ADDR) begin
                                if (rx_byte[7:1] == TGT_ADDR) begin
                                    rw_n   = rx_byte[0];
                                    busy_n = 1'b1;
                                end else begin
                                    st_n = IDLE;
                                end
                            end else if (st == PTR) begin
                                ptr_n = rx_byte[PW-1:0];
                            end else begin
                                wr_valid_n = 1'b1;
                                wr_ptr_n   = ptr;
                                wr_data_n  = rx_byte;
                                ptr_n      = ptr + PW'(1);
                            end
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        st_n     = st == ADDR ? ADDR_ACK : st == PTR ? PTR_ACK : WDATA_ACK;
                        sda_en_n = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        st_n     = rw ? RDATA : PTR;
                        sda_en_n = rw & ~rd_byte[7];
                        sr_n     = {rd_byte[6:0], 1'b0};
                        cnt_n    = {3'b000, rw};
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        st_n     = WDATA;
                        sda_en_n = 1'b0;
                        cnt_n    = '0;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            st_n     = RDATA_ACK;
                            sda_en_n = 1'b0;
                        end else begin
                            sda_en_n = ~(cnt == 4'd0 ? rd_byte[7] : sr[7]);
                            sr_n     = cnt == 4'd0 ? {rd_byte[6:0], 1'b0} : {sr[6:0], 1'b0};
                            cnt_n    = cnt + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        st_n  = sda_s ? IDLE : RDATA;
                        cnt_n = '0;
                        ptr_n = sda_s ? ptr : ptr + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C write/read/abort/reset sequences against i2c_target_regs
module tb_i2c_target_regs;
    localparam int Q = 50;
    logic pclk = 1'b0, presetn = 1'b0, scl = 1'b1, sda_m = 1'b1;
    logic sda, sda_en, busy, wr_valid;
    logic [3:0] wr_ptr;
    logic [7:0] wr_data;
    int n_chk = 0, n_fail = 0, wv_cnt = 0, sda_cnt = 0;
    logic [11:0] wv_log [64];

    assign sda = sda_m & ~sda_en;
    always #5 pclk = ~pclk;

    i2c_target_regs dut (
        .PCLK       (pclk),
        .PRESETn    (presetn),
        .SCL        (scl),
        .SDA        (sda),
        .SDA_ENABLE (sda_en),
        .BUSY       (busy),
        .WR_VALID   (wr_valid),
        .WR_PTR     (wr_ptr),
        .WR_DATA    (wr_data)
    );

    always @(negedge pclk) begin
        if (wr_valid) begin
            wv_log[wv_cnt[5:0]] <= {wr_ptr, wr_data};
            wv_cnt <= wv_cnt + 1;
        end
        if (sda_en) sda_cnt <= sda_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_bit(input logic b, output logic r);
        sda_m = b;
        #Q scl = 1'b1;
        #Q r = sda;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, r);
            d = {d[6:0], r};
        end
        clk_bit(mack, r);
    endtask

    initial begin
        logic a;
        logic [7:0] d;
        int w0, s0;
        #20;
        chk("rst_sda_en", sda_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_wr_data", wr_data, 0);
        #80 presetn = 1'b1;
        #100;
        // write ptr 3 <- 5A, C3
        w0 = wv_cnt;
        i2c_start();
        write_byte(8'hA0, a); chk("w1_addr_ack", a, 0);
        chk("w1_busy", busy, 1);
        write_byte(8'h03, a); chk("w1_ptr_ack", a, 0);
        write_byte(8'h5A, a); chk("w1_d0_ack", a, 0);
        write_byte(8'hC3, a); chk("w1_d1_ack", a, 0);
        i2c_stop();
        chk("w1_nwr", wv_cnt - w0, 2);
        chk("w1_wr0", wv_log[w0], 12'h35A);
        chk("w1_wr1", wv_log[w0+1], 12'h4C3);
        chk("w1_busy_end", busy, 0);
        // repeated-start read back
        w0 = wv_cnt;
        i2c_start();
        write_byte(8'hA0, a); chk("r1_addr_ack", a, 0);
        write_byte(8'h03, a); chk("r1_ptr_ack", a, 0);
        i2c_start();
        write_byte(8'hA1, a); chk("r1_raddr_ack", a, 0);
        read_byte(1'b0, d); chk("r1_d0", d, 8'h5A);
        read_byte(1'b1, d); chk("r1_d1", d, 8'hC3);
        i2c_stop();
        chk("r1_busy_end", busy, 0);
        chk("r1_nwr", wv_cnt - w0, 0);
        // wrong address
        w0 = wv_cnt;
        s0 = sda_cnt;
        i2c_start();
        write_byte(8'hA2, a); chk("na_addr_nack", a, 1);
        write_byte(8'h05, a); chk("na_d_nack", a, 1);
        i2c_stop();
        chk("na_sda_en", sda_cnt - s0, 0);
        chk("na_nwr", wv_cnt - w0, 0);
        chk("na_busy", busy, 0);
        // pointer wrap
        w0 = wv_cnt;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h0F, a);
        write_byte(8'h11, a); chk("wr_d0_ack", a, 0);
        write_byte(8'h22, a); chk("wr_d1_ack", a, 0);
        i2c_stop();
        chk("wr_nwr", wv_cnt - w0, 2);
        chk("wr_wr0", wv_log[w0], 12'hF11);
        chk("wr_wr1", wv_log[w0+1], 12'h022);
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h0F, a);
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(1'b0, d); chk("wr_rd15", d, 8'h11);
        read_byte(1'b1, d); chk("wr_rd0", d, 8'h22);
        i2c_stop();
        // STOP after 5th data bit aborts the byte
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h05, a);
        write_byte(8'h96, a);
        i2c_stop();
        w0 = wv_cnt;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h05, a);
        for (int i = 7; i >= 3; i--) clk_bit(i < 4, a);
        i2c_stop();
        chk("ab_nwr", wv_cnt - w0, 0);
        chk("ab_busy", busy, 0);
        chk("ab_sda_en", sda_en, 0);
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h05, a);
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(1'b1, d); chk("ab_rd5", d, 8'h96);
        i2c_stop();
        // reset during 4th bit of a read of reg4 (C3: bits 1,1,0,0)
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h04, a);
        i2c_start();
        write_byte(8'hA1, a);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, a);
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q chk("rs_drive", sda_en, 1);
        presetn = 1'b0;
        #1 chk("rs_sda_en", sda_en, 0);
        chk("rs_busy", busy, 0);
        #(Q-1) presetn = 1'b1;
        scl = 1'b0;
        #Q;
        s0 = sda_cnt;
        write_byte(8'hA1, a); chk("rs_ignore_nack", a, 1);
        chk("rs_ignore_sda", sda_cnt - s0, 0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, a); chk("rs_addr_ack", a, 0);
        read_byte(1'b1, d); chk("rs_rd0", d, 8'h00);
        i2c_stop();
        chk("rs_busy_end", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
